// File: rtl/instruction_fetch.sv
// Instruction fetch: sequences the PC, reads instruction/immediate words from memory
// and pulses the IR load. Optional memory-timeout fault is enabled by IF_TIMEOUT_EN.
module instruction_fetch #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
`ifdef IF_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        clock,
    input  logic        notReset,
    input  logic        next,
    input  logic        fetchImm,
    input  logic        jump,
    input  logic [15:0] jumpAddr,
    output logic [15:0] memAddr,
    output logic        notMemRead,
    input  logic        memReady,
    input  logic [15:0] memData,
    output logic [15:0] irData,
    output logic        irNotLoad,
    output logic [15:0] immOut,
    output logic        immValid,
    output logic [15:0] pc,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH_I = 2'd1,
        LOAD_I  = 2'd2,
        FETCH_D = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] ir_data_reg, ir_data_next;
    logic [15:0] imm_reg, imm_next;
    logic        imm_valid_reg, imm_valid_next;
    logic        fetching;
    logic        fetch_allowed;
    logic        expired;

    assign fetching = (state_reg == FETCH_I) || (state_reg == FETCH_D);

`ifdef IF_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             fault_reg, fault_next;

    assign expired       = fetching && (cnt_reg == CNT_LAST);
    assign fetch_allowed = !fault_reg;
    assign fault         = fault_reg;

    // Counter is zero whenever IDLE, so every fetch starts its wait budget afresh.
    always_comb begin
        cnt_next   = cnt_reg;
        fault_next = fault_reg;
        if (state_reg == IDLE) begin
            cnt_next = '0;
        end else if (fetching && !memReady) begin
            if (expired) begin
                fault_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!notReset) begin
            cnt_reg   <= '0;
            fault_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            fault_reg <= fault_next;
        end
    end
`else
    assign expired       = 1'b0;
    assign fetch_allowed = 1'b1;
    assign fault         = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        ir_data_next   = ir_data_reg;
        imm_next       = imm_reg;
        imm_valid_next = imm_valid_reg;
        case (state_reg)
            IDLE: begin
                if (jump) begin
                    pc_next        = jumpAddr;
                    imm_valid_next = 1'b0;
                end else if (next && fetch_allowed) begin
                    imm_valid_next = 1'b0;
                    state_next     = FETCH_I;
                end else if (fetchImm && fetch_allowed) begin
                    state_next = FETCH_D;
                end
            end
            FETCH_I: begin
                if (memReady) begin
                    ir_data_next = memData;
                    state_next   = LOAD_I;
                end else if (expired) begin
                    state_next = IDLE;
                end
            end
            LOAD_I: begin
                pc_next    = pc_reg + 16'd1;
                state_next = IDLE;
            end
            FETCH_D: begin
                if (memReady) begin
                    imm_next       = memData;
                    imm_valid_next = 1'b1;
                    pc_next        = pc_reg + 16'd1;
                    state_next     = IDLE;
                end else if (expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!notReset) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_VECTOR;
            ir_data_reg   <= 16'h0000;
            imm_reg       <= 16'h0000;
            imm_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            ir_data_reg   <= ir_data_next;
            imm_reg       <= imm_next;
            imm_valid_reg <= imm_valid_next;
        end
    end

    // Strobes decode straight from the state register so they are glitch-free Moore outputs.
    assign notMemRead = !fetching;
    assign irNotLoad  = (state_reg != LOAD_I);
    assign busy       = (state_reg != IDLE);
    assign memAddr    = pc_reg;
    assign pc         = pc_reg;
    assign irData     = ir_data_reg;
    assign immOut     = imm_reg;
    assign immValid   = imm_valid_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected IR loads and immediates are queued by
// the stimulus and popped by monitors when the DUT presents them.
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        notReset = 1'b0;
    logic        next = 1'b0;
    logic        fetchImm = 1'b0;
    logic        jump = 1'b0;
    logic [15:0] jumpAddr = 16'h0000;
    logic [15:0] memAddr;
    logic        notMemRead;
    logic        memReady = 1'b0;
    logic [15:0] memData = 16'h0000;
    logic [15:0] irData;
    logic        irNotLoad;
    logic [15:0] immOut;
    logic        immValid;
    logic [15:0] pc;
    logic        busy;
    logic        fault;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] addr;
    } ir_exp_t;

    ir_exp_t     exp_ir[$];
    logic [15:0] exp_imm[$];

    int          wait_left = 0;
    int          rd_cnt = 0;
    int          load_cnt = 0;
    logic [15:0] exp_addr = 16'h0000;
    logic        prev_load = 1'b0;
    logic        prev_imm_valid = 1'b0;

`ifdef IF_TIMEOUT_EN
    instruction_fetch #(.RESET_VECTOR(16'h0100), .TIMEOUT_CYCLES(4)) dut (
`else
    instruction_fetch #(.RESET_VECTOR(16'h0100)) dut (
`endif
        .clock(clock), .notReset(notReset), .next(next), .fetchImm(fetchImm),
        .jump(jump), .jumpAddr(jumpAddr), .memAddr(memAddr), .notMemRead(notMemRead),
        .memReady(memReady), .memData(memData), .irData(irData), .irNotLoad(irNotLoad),
        .immOut(immOut), .immValid(immValid), .pc(pc), .busy(busy), .fault(fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Memory model: answers a read after wait_left wait cycles; checks the read address.
    always @(negedge clock) begin
        if (notMemRead === 1'b0) begin
            rd_cnt++;
            check("mem_addr", memAddr, exp_addr);
            if (wait_left == 0) begin
                memReady = 1'b1;
            end else begin
                memReady = 1'b0;
                wait_left--;
            end
        end else begin
            memReady = 1'b0;
        end
    end

    // Monitor: IR load pulses and freshly valid immediates.
    always @(negedge clock) begin
        if (irNotLoad === 1'b0) begin
            load_cnt++;
            if (prev_load) check("ir_pulse_width", 16'd2, 16'd1);
            if (exp_ir.size() == 0) begin
                check("ir_unexpected_load", 16'd1, 16'd0);
            end else begin
                ir_exp_t e;
                e = exp_ir.pop_front();
                check("ir_data", irData, e.data);
                check("ir_load_pc", pc, e.addr);
                check("ir_load_no_read", {15'd0, notMemRead}, 16'd1);
            end
        end
        prev_load = (irNotLoad === 1'b0);
        if (immValid === 1'b1 && !prev_imm_valid) begin
            if (exp_imm.size() == 0) begin
                check("imm_unexpected", 16'd1, 16'd0);
            end else begin
                check("imm_out", immOut, exp_imm.pop_front());
            end
        end
        prev_imm_valid = (immValid === 1'b1);
    end

    initial begin
        int rd0;
        int ld0;
        // Reset for two cycles
        tick(2);
        check("rst_pc", pc, 16'h0100);
        check("rst_irNotLoad", {15'd0, irNotLoad}, 16'd1);
        check("rst_notMemRead", {15'd0, notMemRead}, 16'd1);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_immValid", {15'd0, immValid}, 16'd0);
        check("rst_fault", {15'd0, fault}, 16'd0);
        check("rst_irData", irData, 16'h0000);
        notReset = 1'b1;
        tick(1);

        // Zero-wait instruction fetch
        exp_addr = 16'h0100; memData = 16'hA5C3; wait_left = 0; rd_cnt = 0; load_cnt = 0;
        exp_ir.push_back('{data: 16'hA5C3, addr: 16'h0100});
        next = 1'b1; tick(1); next = 1'b0;
        check("zw_busy", {15'd0, busy}, 16'd1);
        tick(1);
        check("zw_pc_mid", pc, 16'h0100);
        tick(1);
        check("zw_pc", pc, 16'h0101);
        check("zw_idle", {15'd0, busy}, 16'd0);
        check("zw_irData_hold", irData, 16'hA5C3);
        check("zw_reads", rd_cnt[15:0], 16'd1);
        check("zw_loads", load_cnt[15:0], 16'd1);

        // Three wait cycles, next held high throughout the busy period
        exp_addr = 16'h0101; memData = 16'h0F0F; wait_left = 3; rd_cnt = 0; load_cnt = 0;
        exp_ir.push_back('{data: 16'h0F0F, addr: 16'h0101});
        next = 1'b1; tick(5); next = 1'b0;
        tick(3);
        check("ws_reads", rd_cnt[15:0], 16'd4);
        check("ws_loads", load_cnt[15:0], 16'd1);
        check("ws_pc", pc, 16'h0102);

        // Immediate fetch at 0xFFFF wraps PC
        jumpAddr = 16'hFFFF; jump = 1'b1; tick(1); jump = 1'b0;
        check("jmp_ffff", pc, 16'hFFFF);
        exp_addr = 16'hFFFF; memData = 16'h1234; wait_left = 0; rd_cnt = 0; load_cnt = 0;
        exp_imm.push_back(16'h1234);
        fetchImm = 1'b1; tick(1); fetchImm = 1'b0;
        tick(1);
        check("imm_valid", {15'd0, immValid}, 16'd1);
        check("imm_pc_wrap", pc, 16'h0000);
        check("imm_val", immOut, 16'h1234);
        check("imm_no_load", load_cnt[15:0], 16'd0);
        check("imm_reads", rd_cnt[15:0], 16'd1);
        exp_addr = 16'h0000; memData = 16'hBEEF;
        exp_ir.push_back('{data: 16'hBEEF, addr: 16'h0000});
        next = 1'b1; tick(1); next = 1'b0;
        check("imm_cleared", {15'd0, immValid}, 16'd0);
        tick(2);
        check("after_imm_pc", pc, 16'h0001);

        // jump wins over next in the same cycle
        rd_cnt = 0;
        jumpAddr = 16'h2000; jump = 1'b1; next = 1'b1; tick(1); jump = 1'b0; next = 1'b0;
        check("jn_pc", pc, 16'h2000);
        check("jn_busy", {15'd0, busy}, 16'd0);
        tick(1);
        check("jn_no_read", rd_cnt[15:0], 16'd0);
        exp_addr = 16'h2000; memData = 16'h7E81;
        exp_ir.push_back('{data: 16'h7E81, addr: 16'h2000});
        next = 1'b1; tick(1); next = 1'b0;
        tick(2);
        check("jn_pc_after", pc, 16'h2001);
        check("fault_low", {15'd0, fault}, 16'd0);

`ifdef IF_TIMEOUT_EN
        // Memory never answers: fault after four FETCH cycles
        exp_addr = 16'h2001; wait_left = 1000; rd_cnt = 0;
        ld0 = load_cnt;
        next = 1'b1; tick(1); next = 1'b0;
        tick(3);
        check("to_busy_pre", {15'd0, busy}, 16'd1);
        tick(1);
        check("to_fault", {15'd0, fault}, 16'd1);
        check("to_idle", {15'd0, busy}, 16'd0);
        check("to_notMemRead", {15'd0, notMemRead}, 16'd1);
        check("to_pc", pc, 16'h2001);
        check("to_reads", rd_cnt[15:0], 16'd4);
        rd0 = rd_cnt;
        next = 1'b1; tick(1); next = 1'b0;
        tick(2);
        check("to_next_ignored", rd_cnt[15:0], rd0[15:0]);
        check("to_no_load", load_cnt[15:0], ld0[15:0]);
        wait_left = 0;
        notReset = 1'b0; tick(1); notReset = 1'b1;
        check("to_reset_clears", {15'd0, fault}, 16'd0);
`else
        rd0 = rd_cnt;
        ld0 = load_cnt;
        tick(2);
        check("idle_no_read", rd_cnt[15:0], rd0[15:0]);
        check("idle_no_load", load_cnt[15:0], ld0[15:0]);
`endif
        tick(2);
        check("ir_queue_empty", exp_ir.size(), 16'd0);
        check("imm_queue_empty", exp_imm.size(), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Producer side of the instruction register load interface. Sequences the program counter and reads 16-bit words from memory. Presents each word on irData and pulses the IR's active-low load for exactly one cycle. Also fetches the word following an instruction into an immediate holding register when the control unit requests it.

Parameters:
RESET_VECTOR, 16'h0000, PC value after reset.
TIMEOUT_CYCLES, 255, max wait cycles for memReady before fault; only used when IF_TIMEOUT_EN is defined.

Ports:
clock  input  1  system clock; all state changes on rising edge
notReset  input  1  synchronous, active-low reset
next  input  1  control unit requests next instruction word
fetchImm  input  1  control unit requests immediate word at PC
jump  input  1  load PC from jumpAddr
jumpAddr  input  16  jump target
memAddr  output  16  memory address; equals pc combinationally
notMemRead  output  1  active-low memory read strobe
memReady  input  1  memory data valid this cycle
memData  input  16  memory read data
irData  output  16  word presented to IR data input
irNotLoad  output  1  drives IR active-low load enable
immOut  output  16  captured immediate word
immValid  output  1  immOut holds a freshly fetched immediate
pc  output  16  program counter
busy  output  1  fetch in progress; requests ignored
fault  output  1  memory timeout, sticky

Behaviour:
- Reset: clock is the single clock; notReset is synchronous and active-low, sampled on the rising edge. When low: state IDLE, pc=RESET_VECTOR, notMemRead=1, irNotLoad=1, irData=0, immOut=0, immValid=0, busy=0, fault=0, timeout counter=0.
- Reset mid-fetch aborts the fetch. notMemRead=1 and irNotLoad=1 from the next cycle. No IR load pulse is issued.
- States: IDLE, FETCH_I, LOAD_I, FETCH_D.
- IDLE (busy=0, notMemRead=1, irNotLoad=1):
  - Priority is jump > next > fetchImm.
  - jump: pc<=jumpAddr, immValid<=0, stay in IDLE. Any next or fetchImm in the same cycle is dropped.
  - next: immValid<=0, go to FETCH_I.
  - fetchImm: go to FETCH_D.
- FETCH_I (busy=1, notMemRead=0): wait for memReady. When memReady is high, irData<=memData and go to LOAD_I.
- LOAD_I (busy=1, notMemRead=1, irNotLoad=0 for exactly this one cycle): the IR captures irData on the edge that ends LOAD_I. On the same edge pc<=pc+1 and state goes to IDLE.
- FETCH_D (busy=1, notMemRead=0): when memReady is high, immOut<=memData, immValid<=1, pc<=pc+1, go to IDLE.
- Inputs next, fetchImm and jump are ignored while busy=1. The control unit must hold or re-issue them.
- irNotLoad is never low outside LOAD_I. irData is stable from FETCH_I exit through the end of LOAD_I.
- PC increment wraps 16'hFFFF -> 16'h0000 with no flag.
- Latency with zero-wait memory (memReady high in first FETCH cycle):
  - next sampled at edge E0: FETCH_I in cycle E0-E1, LOAD_I in cycle E1-E2, IR loaded and pc incremented at E2, back in IDLE after E2.
  - Immediate fetch: immValid high one edge after entering FETCH_D.
- Each memory wait cycle adds one cycle in the FETCH state.
- memReady outside the FETCH states is ignored.

Optional Feature:
IF_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter clears on entry to FETCH_I/FETCH_D and increments each FETCH cycle without memReady.
  - On reaching TIMEOUT_CYCLES: fault<=1 (sticky until reset), state goes to IDLE, notMemRead=1, pc unchanged, no IR load pulse, immValid unchanged.
  - While fault=1, next and fetchImm are ignored; jump is still accepted.
- Not defined: fault is tied 0 and the FETCH states wait indefinitely.

Test Plan:
- Reset with RESET_VECTOR=16'h0100 and notReset low for 2 cycles -> pc=0x0100, irNotLoad=1, notMemRead=1, busy=0, immValid=0.
- next pulse, memory returns 0xA5C3 with zero wait -> notMemRead low for 1 cycle at memAddr=0x0100; irData=0xA5C3; irNotLoad low exactly 1 cycle; pc=0x0101 two edges after next.
- next with memReady delayed 3 cycles -> notMemRead low 4 cycles; single irNotLoad pulse; next pulses asserted while busy cause no extra fetch.
- fetchImm at pc=0xFFFF, memData=0x1234 -> immOut=0x1234, immValid=1, pc=0x0000, irNotLoad never low; a following next clears immValid.
- jump=1 with next=1 in the same IDLE cycle, jumpAddr=0x2000 -> pc=0x2000, no fetch started; a next on the following cycle reads address 0x2000.
- IF_TIMEOUT_EN, TIMEOUT_CYCLES=4, memReady held low -> fault=1 after 4 FETCH cycles, notMemRead=1, pc unchanged, irNotLoad stays 1; later next ignored; reset clears fault.
